// File: rtl/rp_bary_normalize.sv
// rp_bary_normalize: divides two signed edge numerators by the signed area
// denominator, producing Q0.FRAC_W barycentric weights plus inside/degenerate flags.
module rp_bary_normalize #(
    parameter int IN_W   = 36,
    parameter int FRAC_W = 8,
    parameter int TAG_W  = 20,
    parameter int ROUND  = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   numerator1,
    input  logic [IN_W-1:0]   numerator2,
    input  logic [IN_W-1:0]   denominator,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FRAC_W-1:0] w1,
    output logic [FRAC_W-1:0] w2,
    output logic [FRAC_W-1:0] w3,
    output logic              out_of_bounds,
    output logic              degenerate,
    output logic [TAG_W-1:0]  out_tag
);
    // stage 0 normalises, stages 1..FRAC_W+1 each retire one quotient bit
    localparam int NS = FRAC_W + 2;
    localparam int RW = IN_W + 2;
    localparam int QW = FRAC_W + 1;
    localparam int SW = IN_W + 1;

    localparam logic signed [FRAC_W+2:0] FULL = {3'b001, {FRAC_W{1'b0}}};

    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    logic             vld_d  [NS];
    logic             vld_q  [NS];
    logic [IN_W-1:0]  den_d  [NS];
    logic [IN_W-1:0]  den_q  [NS];
    logic [RW-1:0]    rem1_d [NS];
    logic [RW-1:0]    rem1_q [NS];
    logic [RW-1:0]    rem2_d [NS];
    logic [RW-1:0]    rem2_q [NS];
    logic [QW-1:0]    quo1_d [NS];
    logic [QW-1:0]    quo1_q [NS];
    logic [QW-1:0]    quo2_d [NS];
    logic [QW-1:0]    quo2_q [NS];
    logic             sat1_d [NS];
    logic             sat1_q [NS];
    logic             sat2_d [NS];
    logic             sat2_q [NS];
    logic             oob_d  [NS];
    logic             oob_q  [NS];
    logic             deg_d  [NS];
    logic             deg_q  [NS];
    logic [TAG_W-1:0] tag_d  [NS];
    logic [TAG_W-1:0] tag_q  [NS];

    logic [RW-1:0]    sh1 [NS];
    logic [RW-1:0]    sh2 [NS];
    logic             ge1 [NS];
    logic             ge2 [NS];

    logic                 flip;
    logic signed [SW-1:0] d_s;
    logic signed [SW-1:0] n1_s;
    logic signed [SW-1:0] n2_s;
    logic signed [RW-1:0] sum_s;

    // sign normalisation, exact bounds test and one restoring step per stage
    always_comb begin
        flip  = denominator[IN_W-1];
        d_s   = {denominator[IN_W-1], denominator};
        n1_s  = {numerator1[IN_W-1], numerator1};
        n2_s  = {numerator2[IN_W-1], numerator2};
        if (flip) begin
            d_s  = -d_s;
            n1_s = -n1_s;
            n2_s = -n2_s;
        end
        sum_s = {n1_s[SW-1], n1_s} + {n2_s[SW-1], n2_s};

        vld_d[0]  = in_valid;
        den_d[0]  = d_s[IN_W-1:0];
        rem1_d[0] = {2'b00, n1_s[IN_W-1:0]};
        rem2_d[0] = {2'b00, n2_s[IN_W-1:0]};
        quo1_d[0] = '0;
        quo2_d[0] = '0;
        sat1_d[0] = (n1_s >= d_s);
        sat2_d[0] = (n2_s >= d_s);
        deg_d[0]  = (d_s == '0);
        oob_d[0]  = deg_d[0] | n1_s[SW-1] | n2_s[SW-1]
                  | (sum_s > $signed({1'b0, d_s}));
        tag_d[0]  = in_tag;

        sh1[0] = '0;
        sh2[0] = '0;
        ge1[0] = 1'b0;
        ge2[0] = 1'b0;

        for (int k = 1; k < NS; k++) begin
            sh1[k]    = {rem1_q[k-1][RW-2:0], 1'b0};
            sh2[k]    = {rem2_q[k-1][RW-2:0], 1'b0};
            ge1[k]    = sh1[k] >= {2'b00, den_q[k-1]};
            ge2[k]    = sh2[k] >= {2'b00, den_q[k-1]};
            rem1_d[k] = ge1[k] ? sh1[k] - {2'b00, den_q[k-1]} : sh1[k];
            rem2_d[k] = ge2[k] ? sh2[k] - {2'b00, den_q[k-1]} : sh2[k];
            quo1_d[k] = {quo1_q[k-1][QW-2:0], ge1[k]};
            quo2_d[k] = {quo2_q[k-1][QW-2:0], ge2[k]};
            vld_d[k]  = vld_q[k-1];
            den_d[k]  = den_q[k-1];
            sat1_d[k] = sat1_q[k-1];
            sat2_d[k] = sat2_q[k-1];
            oob_d[k]  = oob_q[k-1];
            deg_d[k]  = deg_q[k-1];
            tag_d[k]  = tag_q[k-1];
        end
    end

    // every pipeline stage moves together on advance and holds otherwise
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NS; k++) begin
                vld_q[k]  <= 1'b0;
                den_q[k]  <= '0;
                rem1_q[k] <= '0;
                rem2_q[k] <= '0;
                quo1_q[k] <= '0;
                quo2_q[k] <= '0;
                sat1_q[k] <= 1'b0;
                sat2_q[k] <= 1'b0;
                oob_q[k]  <= 1'b0;
                deg_q[k]  <= 1'b0;
                tag_q[k]  <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < NS; k++) begin
                vld_q[k]  <= vld_d[k];
                den_q[k]  <= den_d[k];
                rem1_q[k] <= rem1_d[k];
                rem2_q[k] <= rem2_d[k];
                quo1_q[k] <= quo1_d[k];
                quo2_q[k] <= quo2_d[k];
                sat1_q[k] <= sat1_d[k];
                sat2_q[k] <= sat2_d[k];
                oob_q[k]  <= oob_d[k];
                deg_q[k]  <= deg_d[k];
                tag_q[k]  <= tag_d[k];
            end
        end
    end

    logic              rb1;
    logic              rb2;
    logic [QW-1:0]     qf1;
    logic [QW-1:0]     qf2;
    logic [FRAC_W-1:0] w1_d;
    logic [FRAC_W-1:0] w2_d;
    logic [FRAC_W-1:0] w3_d;
    logic signed [FRAC_W+2:0] w3_s;

    // drop the extra quotient bit (or round on it), saturate, derive w3
    always_comb begin
        rb1  = (ROUND != 0) & quo1_q[NS-1][0];
        rb2  = (ROUND != 0) & quo2_q[NS-1][0];
        qf1  = {1'b0, quo1_q[NS-1][QW-1:1]} + {{FRAC_W{1'b0}}, rb1};
        qf2  = {1'b0, quo2_q[NS-1][QW-1:1]} + {{FRAC_W{1'b0}}, rb2};
        w1_d = (sat1_q[NS-1] | qf1[FRAC_W]) ? '1 : qf1[FRAC_W-1:0];
        w2_d = (sat2_q[NS-1] | qf2[FRAC_W]) ? '1 : qf2[FRAC_W-1:0];
        w3_s = FULL - $signed({3'b000, w1_d}) - $signed({3'b000, w2_d});
        if (w3_s[FRAC_W+2]) begin
            w3_d = '0;
        end else if (w3_s[FRAC_W+1:FRAC_W] != 2'b00) begin
            w3_d = '1;
        end else begin
            w3_d = w3_s[FRAC_W-1:0];
        end
        if (oob_q[NS-1]) begin
            w1_d = '0;
            w2_d = '0;
            w3_d = '0;
        end
    end

    logic              ov_q;
    logic [FRAC_W-1:0] w1_q;
    logic [FRAC_W-1:0] w2_q;
    logic [FRAC_W-1:0] w3_q;
    logic              ob_q;
    logic              dg_q;
    logic [TAG_W-1:0]  ot_q;

    // output register, held stable while downstream stalls
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ov_q <= 1'b0;
            w1_q <= '0;
            w2_q <= '0;
            w3_q <= '0;
            ob_q <= 1'b0;
            dg_q <= 1'b0;
            ot_q <= '0;
        end else if (advance) begin
            ov_q <= vld_q[NS-1];
            w1_q <= w1_d;
            w2_q <= w2_d;
            w3_q <= w3_d;
            ob_q <= oob_q[NS-1];
            dg_q <= deg_q[NS-1];
            ot_q <= tag_q[NS-1];
        end
    end

    assign out_valid     = ov_q;
    assign w1            = w1_q;
    assign w2            = w2_q;
    assign w3            = w3_q;
    assign out_of_bounds = ob_q;
    assign degenerate    = dg_q;
    assign out_tag       = ot_q;

endmodule
